// File: rtl/register_file_if.sv
// Register file access bus: WB-stage write port, two ID-stage read ports,
// and write-activity status. The master drives the indices, write data and
// strobe. The slave (register_file) returns read data and status.
interface register_file_if #(
   parameter int DATA_W = 16,
   parameter int ADDR_W = 3
);
   logic              reg_write_en;
   logic [ADDR_W-1:0] reg_write_dest;
   logic [DATA_W-1:0] reg_write_data;
   logic [ADDR_W-1:0] reg_read_addr_1;
   logic [DATA_W-1:0] reg_read_data_1;
   logic [ADDR_W-1:0] reg_read_addr_2;
   logic [DATA_W-1:0] reg_read_data_2;
   logic [15:0]       wr_count;
   logic [ADDR_W-1:0] last_wr_dest;

   modport master (
      output reg_write_en, reg_write_dest, reg_write_data,
      output reg_read_addr_1, reg_read_addr_2,
      input  reg_read_data_1, reg_read_data_2, wr_count, last_wr_dest
   );

   modport slave (
      input  reg_write_en, reg_write_dest, reg_write_data,
      input  reg_read_addr_1, reg_read_addr_2,
      output reg_read_data_1, reg_read_data_2, wr_count, last_wr_dest
   );
endinterface

// File: rtl/register_file.sv
// Eight-entry 16-bit register file with two combinational read ports and
// one synchronous write port. R0 is hardwired to zero.
// The design also tracks a saturating count of committed writes and the
// index of the most recent committed write.
// Optional feature: define REG_WRITE_BYPASS_EN to forward same-cycle write
// data onto a matching read port (write-through). Without it, a read returns
// the stored value until the clock edge.
module register_file #(
   parameter int NUM_REGS = 8,
   parameter int DATA_W   = 16,
   parameter int ADDR_W   = 3
) (
   input logic              clk,
   input logic              rst,
   register_file_if.slave   bus
);

   logic [DATA_W-1:0] regs [NUM_REGS];
   logic [15:0]       wr_count_q;
   logic [ADDR_W-1:0] last_wr_dest_q;
   logic              commit;

   // A write only counts when it targets a real (nonzero) register.
   assign commit = bus.reg_write_en && (bus.reg_write_dest != '0);

   // Register storage: cleared asynchronously, written on commit. R0 is never written.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
      end else begin
         for (int i = 1; i < NUM_REGS; i++)
            if (commit && (bus.reg_write_dest == ADDR_W'(i))) regs[i] <= bus.reg_write_data;
      end
   end

   // Write statistics: saturating commit count and last destination.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_count_q     <= '0;
         last_wr_dest_q <= '0;
      end else if (commit) begin
         if (wr_count_q != '1) wr_count_q <= wr_count_q + 16'd1;
         last_wr_dest_q <= bus.reg_write_dest;
      end
   end

   function automatic logic [DATA_W-1:0] rd_mux(input logic [ADDR_W-1:0] addr);
      logic [DATA_W-1:0] v;
      v = '0;
      if (addr != '0) begin
         v = regs[addr];
`ifdef REG_WRITE_BYPASS_EN
         // Bypassing is suppressed during reset so reads still return zero.
         if (rst && commit && (addr == bus.reg_write_dest)) v = bus.reg_write_data;
`endif
      end
      return v;
   endfunction

   // Combinational read ports; address 0 always returns zero.
   always_comb begin
      bus.reg_read_data_1 = rd_mux(bus.reg_read_addr_1);
      bus.reg_read_data_2 = rd_mux(bus.reg_read_addr_2);
   end

   assign bus.wr_count     = wr_count_q;
   assign bus.last_wr_dest = last_wr_dest_q;

endmodule

// File: tb/tb_register_file.sv
// Testbench for register_file. Stimulus pushes expected values into a
// scoreboard queue. A monitor pops and compares them on the falling edge.
// Expectations for same-cycle reads follow REG_WRITE_BYPASS_EN.
module tb_register_file;

   logic clk = 1'b0;
   logic rst = 1'b0;

   register_file_if bus ();

   register_file dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   typedef struct {
      string       name;
      int          sel;   // 0 rd1, 1 rd2, 2 wr_count, 3 last_wr_dest
      logic [15:0] exp;
   } chk_t;

   chk_t q[$];
   int   checks = 0;
   int   errors = 0;

`ifdef REG_WRITE_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif

   task automatic expect_val(input string name, input int sel, input logic [15:0] exp);
      chk_t c;
      c.name = name;
      c.sel  = sel;
      c.exp  = exp;
      q.push_back(c);
   endtask

   task automatic drive_w(input logic en, input logic [2:0] dest, input logic [15:0] data);
      bus.reg_write_en   = en;
      bus.reg_write_dest = dest;
      bus.reg_write_data = data;
   endtask

   task automatic drive_r(input logic [2:0] a1, input logic [2:0] a2);
      bus.reg_read_addr_1 = a1;
      bus.reg_read_addr_2 = a2;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Monitor: compare every pending expectation against the live outputs.
   initial begin
      forever begin
         @(negedge clk);
         while (q.size() != 0) begin
            chk_t c;
            logic [15:0] act;
            c = q.pop_front();
            case (c.sel)
               0:       act = bus.reg_read_data_1;
               1:       act = bus.reg_read_data_2;
               2:       act = bus.wr_count;
               default: act = {13'd0, bus.last_wr_dest};
            endcase
            checks++;
            if (act !== c.exp) begin
               errors++;
               $display("FAIL %s got %h expected %h", c.name, act, c.exp);
            end
         end
      end
   end

   // Watchdog.
   initial begin
      #2_000_000;
      $display("FAIL watchdog timeout");
      $fatal(1, "timeout");
   end

   initial begin
      drive_w(1'b1, 3'd4, 16'h1111);
      drive_r(3'd4, 3'd0);
      // Reset state, with a write presented during reset.
      expect_val("rst_rd1", 0, 16'h0000);
      expect_val("rst_rd2", 1, 16'h0000);
      expect_val("rst_cnt", 2, 16'h0000);
      expect_val("rst_last", 3, 16'h0000);
      tick();
      rst = 1'b1;
      drive_w(1'b0, 3'd0, 16'h0000);
      expect_val("rst_wr_ignored", 0, 16'h0000);
      expect_val("rst_wr_cnt", 2, 16'h0000);
      tick();

      // Write R5 and read it on both ports.
      drive_w(1'b1, 3'd5, 16'hBEEF);
      drive_r(3'd5, 3'd5);
      expect_val("r5_same_cyc_1", 0, BYP ? 16'hBEEF : 16'h0000);
      expect_val("r5_same_cyc_2", 1, BYP ? 16'hBEEF : 16'h0000);
      tick();
      drive_w(1'b0, 3'd0, 16'h0000);
      expect_val("r5_rd1", 0, 16'hBEEF);
      expect_val("r5_rd2", 1, 16'hBEEF);
      expect_val("r5_cnt", 2, 16'd1);
      expect_val("r5_last", 3, 16'd5);
      tick();

      // Write to R0 is discarded.
      drive_w(1'b1, 3'd0, 16'hFFFF);
      drive_r(3'd0, 3'd0);
      expect_val("r0_same_cyc", 0, 16'h0000);
      tick();
      drive_w(1'b0, 3'd0, 16'h0000);
      expect_val("r0_rd1", 0, 16'h0000);
      expect_val("r0_rd2", 1, 16'h0000);
      expect_val("r0_cnt", 2, 16'd1);
      expect_val("r0_last", 3, 16'd5);
      tick();

      // Disabled write is ignored.
      drive_w(1'b0, 3'd7, 16'h5555);
      drive_r(3'd7, 3'd5);
      tick();
      expect_val("wen0_r7", 0, 16'h0000);
      expect_val("wen0_cnt", 2, 16'd1);
      expect_val("wen0_last", 3, 16'd5);
      tick();

      // Same-cycle read/write hazard on R2.
      drive_w(1'b1, 3'd2, 16'h0001);
      tick();
      drive_w(1'b1, 3'd2, 16'hA5A5);
      drive_r(3'd2, 3'd5);
      expect_val("haz_before", 0, BYP ? 16'hA5A5 : 16'h0001);
      expect_val("haz_other", 1, 16'hBEEF);
      expect_val("haz_cnt_pre", 2, 16'd2);
      tick();
      drive_w(1'b0, 3'd0, 16'h0000);
      expect_val("haz_after", 0, 16'hA5A5);
      expect_val("haz_cnt", 2, 16'd3);
      expect_val("haz_last", 3, 16'd2);
      tick();

      // Back-to-back writes to R7 and R1.
      drive_w(1'b1, 3'd7, 16'h7777);
      tick();
      drive_w(1'b1, 3'd1, 16'h8001);
      tick();
      drive_w(1'b0, 3'd0, 16'h0000);
      drive_r(3'd7, 3'd1);
      expect_val("b2b_r7", 0, 16'h7777);
      expect_val("b2b_r1", 1, 16'h8001);
      expect_val("b2b_cnt", 2, 16'd5);
      expect_val("b2b_last", 3, 16'd1);
      tick();

      // Mid-run reset clears state without a clock edge.
      drive_w(1'b1, 3'd3, 16'h1234);
      tick();
      drive_w(1'b0, 3'd0, 16'h0000);
      drive_r(3'd3, 3'd7);
      expect_val("r3_rd", 0, 16'h1234);
      expect_val("r3_cnt", 2, 16'd6);
      expect_val("r3_last", 3, 16'd3);
      tick();
      rst = 1'b0;
      drive_w(1'b1, 3'd6, 16'h6666);
      expect_val("mrst_r3", 0, 16'h0000);
      expect_val("mrst_r7", 1, 16'h0000);
      expect_val("mrst_cnt", 2, 16'h0000);
      expect_val("mrst_last", 3, 16'h0000);
      tick();
      drive_r(3'd3, 3'd6);
      expect_val("mrst_r6_held", 1, 16'h0000);
      tick();
      rst = 1'b1;
      drive_w(1'b1, 3'd1, 16'h0042);
      drive_r(3'd6, 3'd1);
      expect_val("mrst_r6_lost", 0, 16'h0000);
      expect_val("first_wr_pre", 1, BYP ? 16'h0042 : 16'h0000);
      expect_val("first_wr_cnt_pre", 2, 16'h0000);
      tick();
      drive_w(1'b0, 3'd0, 16'h0000);
      expect_val("first_wr_rd", 1, 16'h0042);
      expect_val("first_wr_cnt", 2, 16'd1);
      expect_val("first_wr_last", 3, 16'd1);
      tick();

      // Saturation: 65540 more commits from a count of 1.
      for (int i = 0; i < 65540; i++) begin
         drive_w(1'b1, 3'((i % 7) + 1), 16'(i));
         tick();
         if (i == 65532) expect_val("sat_fffe", 2, 16'hFFFE);
         if (i == 65533) expect_val("sat_ffff", 2, 16'hFFFF);
      end
      drive_w(1'b0, 3'd0, 16'h0000);
      expect_val("sat_hold", 2, 16'hFFFF);
      expect_val("sat_last", 3, 16'd6);
      tick();

      // Drain the scoreboard with a bounded wait.
      for (int n = 0; n < 4 && q.size() != 0; n++) @(negedge clk);
      #1;
      checks++;
      if (q.size() != 0) begin
         errors++;
         $display("FAIL drain pending %0d expected 0", q.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/register_file.md
REGISTER_FILE -- requirements
Module: register_file

Interface
REQ-001 SHALL provide: clk  input  1  sole clock; all state updates on rising edge.
REQ-002 SHALL provide: rst  input  1  asynchronous, active-low reset (asserted when 0).
REQ-003 SHALL provide: reg_write_en  input  1  write strobe from the WB stage.
REQ-004 SHALL provide: reg_write_dest  input  3  destination register index from the WB stage.
REQ-005 SHALL provide: reg_write_data  input  16  write data from the WB stage.
REQ-006 SHALL provide: reg_read_addr_1  input  3  read port 1 index (ID stage, rs).
REQ-007 SHALL provide: reg_read_data_1  output  16  read port 1 data.
REQ-008 SHALL provide: reg_read_addr_2  input  3  read port 2 index (ID stage, rt).
REQ-009 SHALL provide: reg_read_data_2  output  16  read port 2 data.
REQ-010 SHALL provide: wr_count  output  16  saturating count of committed writes.
REQ-011 SHALL provide: last_wr_dest  output  3  index of the most recent committed write.

Function
REQ-012 SHALL hold eight 16-bit registers, R0..R7.
REQ-013 SHALL read R0 as 16'h0000 on both ports at all times.
REQ-014 SHALL commit reg_write_data into R[reg_write_dest] on the rising clk edge when reg_write_en=1 and reg_write_dest!=0; latency 1 cycle.
REQ-015 SHALL discard writes to R0 and leave wr_count and last_wr_dest unchanged for them.
REQ-016 SHALL drive both read ports combinationally from the addressed register; read latency 0 cycles.
REQ-017 SHALL allow both read ports to address the same register simultaneously with identical results.
REQ-018 SHALL increment wr_count by 1 on each committed write and saturate at 16'hFFFF, with no wrap to 0.
REQ-019 SHALL update last_wr_dest to reg_write_dest on each committed write.
REQ-020 SHALL ignore reg_write_dest and reg_write_data when reg_write_en=0.
REQ-021 SHALL, when a read and a write target the same nonzero register in the same cycle, return the value selected by REQ-027 or REQ-028 until the clock edge, and the new value after it.

Reset
REQ-022 SHALL, while rst=0, force R1..R7 to 16'h0000, wr_count to 16'h0000 and last_wr_dest to 3'd0, independent of clk.
REQ-023 SHALL ignore any write presented while rst=0.
REQ-024 SHALL, on reset assertion mid-operation, lose all register contents and not complete any pending write.
REQ-025 SHALL leave read ports combinational during reset, so they return 16'h0000 for every index.
REQ-026 SHALL accept writes from the first rising clk edge after rst returns to 1.

Configuration
REQ-027 SHALL, when macro REG_WRITE_BYPASS_EN is defined, forward reg_write_data to any read port whose address equals reg_write_dest while reg_write_en=1, dest!=0 and rst=1, giving write-through behaviour in the same cycle.
REQ-028 SHALL, when REG_WRITE_BYPASS_EN is undefined, return the pre-write stored value in that case; the new value becomes visible the cycle after the edge.

Verification
REQ-029 SHALL cover: rst=0 pulse mid-run after R3=16'h1234 -> R3 reads 16'h0000, wr_count=0, last_wr_dest=0 with no clk edge needed.
REQ-030 SHALL cover: write R5=16'hBEEF, then read addr_1=5, addr_2=5 -> both ports return 16'hBEEF one cycle later; wr_count=1; last_wr_dest=5.
REQ-031 SHALL cover: write R0=16'hFFFF -> R0 reads 16'h0000; wr_count and last_wr_dest unchanged.
REQ-032 SHALL cover: same-cycle write R2=16'hA5A5 with read addr_1=2, old R2=16'h0001 -> reg_read_data_1 returns 16'hA5A5 with REG_WRITE_BYPASS_EN defined and 16'h0001 without it; 16'hA5A5 after the edge in both builds.
REQ-033 SHALL cover: 65,540 consecutive committed writes -> wr_count holds 16'hFFFF and does not wrap.
REQ-034 SHALL cover: reg_write_en=0 with dest=7, data=16'h5555 -> R7 and wr_count unchanged.
